// File: rtl/pmsi_pkg.sv
// PMSI coherence encodings, opcodes and the per-line transition function shared by the
// state array and its decoder.
package pmsi_pkg;

    localparam logic [3:0] ST_I   = 4'd1;
    localparam logic [3:0] ST_S   = 4'd2;
    localparam logic [3:0] ST_M   = 4'd4;
    localparam logic [3:0] ST_PS  = 4'd9;
    localparam logic [3:0] ST_PM  = 4'd10;
    localparam logic [3:0] ST_PL  = 4'd11;
    localparam logic [3:0] ST_PLS = 4'd15;

    localparam logic [1:0] PIPE_NONE = 2'd0;
    localparam logic [1:0] PIPE_LD   = 2'd1;
    localparam logic [1:0] PIPE_ST   = 2'd2;

    localparam logic [2:0] L2_NONE  = 3'd0;
    localparam logic [2:0] L2_RD    = 3'd1;
    localparam logic [2:0] L2_WR    = 3'd2;
    localparam logic [2:0] L2_INV   = 3'd3;
    localparam logic [2:0] L2_UPD   = 3'd4;
    localparam logic [2:0] L2_WR_LD = 3'd5;
    localparam logic [2:0] L2_RINV  = 3'd6;

    typedef struct packed {
        logic [3:0] state;
        logic       wb;
        logic       nack;
    } pmsi_result_t;

    function automatic logic is_pending(input logic [3:0] s);
        return s[3];
    endfunction

    function automatic pmsi_result_t pmsi_next(input logic       isL2,
                                               input logic [1:0] pipeOp,
                                               input logic [2:0] l2Op,
                                               input logic       evict,
                                               input logic [3:0] cur);
        pmsi_result_t res;
        res.state = cur;
        res.wb    = 1'b0;
        res.nack  = 1'b0;
        if (isL2) begin
            if (l2Op == L2_INV || l2Op == L2_RINV) begin
                res.state = ST_I;
                // Only a recall-invalidate preserves dirty data; plain INV drops it.
                res.wb    = (l2Op == L2_RINV) && (cur == ST_M);
            end else begin
                case (cur)
                    ST_PL:   if (l2Op == L2_WR || l2Op == L2_WR_LD) res.state = ST_S;
                    ST_PLS:  if (l2Op == L2_WR) res.state = ST_PM;
                             else if (l2Op == L2_WR_LD) res.state = ST_M;
                    ST_PS:   if (l2Op == L2_WR || l2Op == L2_WR_LD) res.state = ST_M;
                    ST_PM:   if (l2Op == L2_UPD) res.state = ST_M;
                    ST_M:    if (l2Op == L2_RD) begin
                                 res.state = ST_S;
                                 res.wb    = 1'b1;
                             end
                    default: ;
                endcase
            end
        end else if (evict && (pipeOp == PIPE_LD || pipeOp == PIPE_ST)) begin
            // A victim still waiting on L2 cannot be replaced.
            if (is_pending(cur)) begin
                res.nack = 1'b1;
            end else begin
                res.state = (pipeOp == PIPE_LD) ? ST_PL : ST_PS;
                res.wb    = (cur == ST_M);
            end
        end else begin
            case (cur)
                ST_I:    if (pipeOp == PIPE_LD) res.state = ST_PL;
                         else if (pipeOp == PIPE_ST) res.state = ST_PS;
                ST_PL:   if (pipeOp == PIPE_ST) res.state = ST_PLS;
                ST_S:    if (pipeOp == PIPE_ST) res.state = ST_PM;
                default: ;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/pmsi_next_state_v2.sv
// Combinational PMSI transition decoder: next state plus writeback and nack flags for
// the single op selected by the arbiter.
module pmsi_next_state_v2
    import pmsi_pkg::*;
(
    input  logic       i_isL2,
    input  logic [1:0] i_pipeOp,
    input  logic [2:0] i_l2Op,
    input  logic       i_evict,
    input  logic [3:0] i_curState,
    output logic [3:0] o_nextState,
    output logic       o_wb,
    output logic       o_nack
);

    pmsi_result_t w_res;

    assign w_res       = pmsi_next(i_isL2, i_pipeOp, i_l2Op, i_evict, i_curState);
    assign o_nextState = w_res.state;
    assign o_wb        = w_res.wb;
    assign o_nack      = w_res.nack;

endmodule

// File: rtl/pmsi_state_array.sv
// Per-bank PMSI state store: L2-priority arbiter, flop state array, registered response
// and a pending-line counter that throttles the pipeline.
module pmsi_state_array
    import pmsi_pkg::*;
#(
    parameter int  NUM_SETS    = 64,
    parameter int  NUM_WAYS    = 4,
    parameter int  MAX_PENDING = 8,
    localparam int SET_W       = $clog2(NUM_SETS),
    localparam int WAY_W       = $clog2(NUM_WAYS),
    localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipe_valid,
    input  logic [1:0]       pipe_op,
    input  logic             pipe_evict,
    input  logic [SET_W-1:0] pipe_set,
    input  logic [WAY_W-1:0] pipe_way,
    output logic             pipe_ready,
    input  logic             l2_valid,
    input  logic [2:0]       l2_op,
    input  logic [SET_W-1:0] l2_set,
    input  logic [WAY_W-1:0] l2_way,
    output logic             rsp_valid,
    output logic             rsp_src,
    output logic [3:0]       rsp_prev_state,
    output logic [3:0]       rsp_state,
    output logic             rsp_wb_to_l2,
    output logic             rsp_nack,
    input  logic [SET_W-1:0] lkp_set,
    input  logic [WAY_W-1:0] lkp_way,
    output logic [3:0]       lkp_state,
    output logic [CNT_W-1:0] pending_cnt
);

    localparam int LINES = NUM_SETS * NUM_WAYS;
    localparam int IDX_W = SET_W + WAY_W;

    logic [3:0]       r_array [LINES];
    logic             r_rspValid;
    logic             r_rspSrc;
    logic [3:0]       r_rspPrev;
    logic [3:0]       r_rspState;
    logic             r_rspWb;
    logic             r_rspNack;
    logic [CNT_W-1:0] r_pendingCnt;

    logic             w_pipeReady;
    logic             w_pipeAcc;
    logic             w_doOp;
    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_curState;
    logic [3:0]       w_nextState;
    logic             w_wb;
    logic             w_nack;
    logic             w_wasPend;
    logic             w_nowPend;

    // L2 always wins; the pipeline also stalls whenever the pending budget is exhausted.
    assign w_pipeReady = !l2_valid && (r_pendingCnt < CNT_W'(MAX_PENDING));
    assign w_pipeAcc   = pipe_valid && w_pipeReady;
    assign w_doOp      = l2_valid ? (l2_op != L2_NONE) : (w_pipeAcc && pipe_op != PIPE_NONE);
    assign w_idx       = l2_valid ? {l2_set, l2_way} : {pipe_set, pipe_way};
    assign w_curState  = r_array[w_idx];

    pmsi_next_state_v2 u_nextState (
        .i_isL2      (l2_valid),
        .i_pipeOp    (pipe_op),
        .i_l2Op      (l2_op),
        .i_evict     (pipe_evict),
        .i_curState  (w_curState),
        .o_nextState (w_nextState),
        .o_wb        (w_wb),
        .o_nack      (w_nack)
    );

    assign w_wasPend = is_pending(w_curState);
    assign w_nowPend = is_pending(w_nextState);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LINES; i++) begin
                r_array[i] <= ST_I;
            end
            r_rspValid   <= 1'b0;
            r_rspSrc     <= 1'b0;
            r_rspPrev    <= ST_I;
            r_rspState   <= ST_I;
            r_rspWb      <= 1'b0;
            r_rspNack    <= 1'b0;
            r_pendingCnt <= '0;
        end else begin
            r_rspValid <= w_doOp;
            if (w_doOp) begin
                r_array[w_idx] <= w_nextState;
                r_rspSrc       <= l2_valid;
                r_rspPrev      <= w_curState;
                r_rspState     <= w_nextState;
                r_rspWb        <= w_wb;
                r_rspNack      <= w_nack;
                if (!w_wasPend && w_nowPend) begin
                    r_pendingCnt <= r_pendingCnt + 1'b1;
                end else if (w_wasPend && !w_nowPend) begin
                    r_pendingCnt <= r_pendingCnt - 1'b1;
                end
            end
        end
    end

    assign pipe_ready     = w_pipeReady;
    assign rsp_valid      = r_rspValid;
    assign rsp_src        = r_rspSrc;
    assign rsp_prev_state = r_rspPrev;
    assign rsp_state      = r_rspState;
    assign rsp_wb_to_l2   = r_rspWb;
    assign rsp_nack       = r_rspNack;
    assign lkp_state      = r_array[{lkp_set, lkp_way}];
    assign pending_cnt    = r_pendingCnt;

endmodule

// File: doc/pmsi_state_array.md
# pmsi_state_array

Parametrised PMSI coherence state store for one cache bank. Holds the per-line state for NUM_SETS × NUM_WAYS lines and applies one coherence operation per cycle, from either the pipeline (LD/ST) or L2 (RD/WR/INV/UPD/WR_LD/RINV). Tracks outstanding pending lines and throttles the pipeline against a MAX_PENDING limit. Sits between the bank's tag/data arrays and the L2 interface.

## Interface
- NUM_SETS, 64, sets per bank (power of 2)
- NUM_WAYS, 4, ways per set (power of 2, ≥2)
- MAX_PENDING, 8, max lines simultaneously in PL/PS/PM/PLS
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pipe_valid  in  1  pipeline op present
- pipe_op  in  2  0 NONE, 1 LD, 2 ST
- pipe_evict  in  1  op replaces the victim line at pipe_set/pipe_way
- pipe_set / pipe_way  in  SET_W / WAY_W  target line
- pipe_ready  out  1  pipeline op accepted this cycle
- l2_valid  in  1  L2 op present (always accepted)
- l2_op  in  3  0 NONE, 1 RD, 2 WR, 3 INV, 4 UPD, 5 WR_LD, 6 RINV
- l2_set / l2_way  in  SET_W / WAY_W  target line
- rsp_valid  out  1  result of op accepted last cycle
- rsp_src  out  1  0 pipeline, 1 L2
- rsp_prev_state / rsp_state  out  4  state before / after
- rsp_wb_to_l2  out  1  line data must be written back to L2
- rsp_nack  out  1  op rejected, state unchanged
- lkp_set / lkp_way  in  SET_W / WAY_W  lookup address
- lkp_state  out  4  combinational read of stored state
- pending_cnt  out  $clog2(MAX_PENDING+1)  lines currently pending

## Operation
- Encodings: I=1, S=2, M=4, PS=9, PM=10, PL=11, PLS=15. Bit 3 set means pending. RINV has its own opcode and never aliases ST.
- Arbitration: L2 has absolute priority. pipe_ready = !l2_valid && pending_cnt < MAX_PENDING. An op is accepted when valid (and ready, for the pipeline). NONE ops are accepted and produce no response.
- Transitions; anything unlisted holds the state:
  - I: LD→PL, ST→PS
  - PL: WR→S, WR_LD→S, ST→PLS, INV/RINV→I
  - PLS: WR→PM, WR_LD→M, INV/RINV→I
  - PS: WR→M, WR_LD→M, INV/RINV→I
  - PM: UPD→M, INV/RINV→I
  - S: ST→PM, INV/RINV→I
  - M: RD→S, INV/RINV→I
- Evict (pipe_evict with LD/ST):
  - Non-pending line: the new state is PL for LD or PS for ST. rsp_wb_to_l2=1 only if the previous state was M.
  - Pending line: rsp_nack=1 and the state is unchanged.
- rsp_wb_to_l2 is also 1 for M+RD and M+RINV. A plain INV of M discards the data, with wb=0.
- pending_cnt increments on a non-pending→pending transition and decrements on pending→non-pending. At most ±1 per cycle.

## Timing
- Single stage. At the accepting edge, the array entry is written and all rsp_* outputs are registered. rsp_valid is high for exactly one cycle after acceptance.
- Back-to-back ops to the same line see the updated state (the array write completes before the next read).
- lkp_state returns the array contents as of the current cycle, with no bypass of the same-edge write.
- Reset:
  - Every line becomes I.
  - rsp_valid=0, rsp_nack=0, rsp_wb_to_l2=0, rsp_src=0, rsp_state=rsp_prev_state=I.
  - pending_cnt=0.
  - pipe_ready follows its equation: 1 when l2_valid=0.
- Reset asserted mid-operation drops the in-flight response; no rsp_valid appears in the following cycle.
- Full: when pending_cnt==MAX_PENDING, pipe_ready=0 even for ops that would not allocate. L2 ops are still processed and can free entries; pipe_ready rises the cycle after the count drops.
- Out-of-range sets/ways are impossible by construction of the widths, where SET_W=$clog2(NUM_SETS) and WAY_W=$clog2(NUM_WAYS).

## Structure
- Package pmsi_pkg holds:
  - the state and opcode localparams
  - an is_pending() function
  - the PMSI next-state function
- Sub-module pmsi_next_state_v2 is a purely combinational transition and writeback/nack decoder, instantiated once on the arbitrated op.
- The array is a flop array NUM_SETS*NUM_WAYS × 4 bits, plus the arbiter and the pending counter.

## Test plan
- Reset, then lkp every line → all return 1 (I). pending_cnt=0, rsp_valid=0.
- Pipe LD set 5 way 2 → next cycle rsp_state=11, pending_cnt=1. L2 WR same line → rsp_state=2, pending_cnt=0.
- Line in M (via ST, then L2 WR), then pipe LD with evict → rsp_prev_state=4, rsp_state=11, rsp_wb_to_l2=1. Repeat evict on that now-PL line → rsp_nack=1, state stays 11.
- Simultaneous pipe ST and L2 INV to the same line → pipe_ready=0, L2 rsp first (rsp_src=1). Pipe ST is accepted the next cycle.
- Issue 8 LDs to distinct lines → pending_cnt=8, pipe_ready=0. One L2 WR → pending_cnt=7, pipe_ready=1 the following cycle.
- Line in M, L2 RINV → rsp_state=1, rsp_wb_to_l2=1. Line in PS with L2 RINV → state 1, wb=0, pending_cnt decrements.
